// File: rtl/alu16_flags.sv
// alu16_flags: registered integer ALU (ADD, SUB, AND, OR, XOR) with
// sign, zero, carry, parity and signed-overflow flags, one cycle of latency.
// Optional feature: define ALU_STICKY_OVF_EN to add a sticky overflow
// output (v_sticky) with a clear input (v_clr).
module alu16_flags #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             sn,
    output logic             ZR,
    output logic             carry,
    output logic             P,
    output logic             V
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic             v_clr,
    output logic             v_sticky
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam int MSB = WIDTH - 1;

    // Combinational result of the current operands (before the hold mux).
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] res_calc;
    logic             carry_calc;
    logic             v_calc;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] s_d, s_q;
    logic             sn_d, sn_q;
    logic             zr_d, zr_q;
    logic             carry_d, carry_q;
    logic             p_d, p_q;
    logic             v_d, v_q;

    // Compute the result and the op-dependent flags (carry, overflow) from a, b and op.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        sum_ext    = '0;
        res_calc   = '0;
        carry_calc = 1'b0;
        v_calc     = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum_ext    = {1'b0, a} + {1'b0, b};
                res_calc   = sum_ext[WIDTH-1:0];
                carry_calc = sum_ext[WIDTH];
                v_calc     = (a[MSB] == b[MSB]) && (res_calc[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // a + ~b + 1: the carry-out is "no borrow", so the borrow flag is its inverse.
                sum_ext    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                res_calc   = sum_ext[WIDTH-1:0];
                carry_calc = ~sum_ext[WIDTH];
                v_calc     = (a[MSB] != b[MSB]) && (res_calc[MSB] != a[MSB]);
            end
            OP_AND:  res_calc = a & b;
            OP_OR:   res_calc = a | b;
            OP_XOR:  res_calc = a ^ b;
            default: res_calc = '0;  // reserved ops produce zero with clear carry/overflow
        endcase
    end

    // Select next register state: capture a new result on in_valid, otherwise hold.
    always_comb begin
        out_valid_d = in_valid;
        s_d         = s_q;
        sn_d        = sn_q;
        zr_d        = zr_q;
        carry_d     = carry_q;
        p_d         = p_q;
        v_d         = v_q;
        if (in_valid) begin
            s_d     = res_calc;
            sn_d    = res_calc[MSB];
            zr_d    = (res_calc == '0);
            carry_d = carry_calc;
            p_d     = ~(^res_calc);
            v_d     = v_calc;
        end
    end

    // Result and flag registers; synchronous reset wins over a new operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            sn_q        <= 1'b0;
            zr_q        <= 1'b0;
            carry_q     <= 1'b0;
            p_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            sn_q        <= sn_d;
            zr_q        <= zr_d;
            carry_q     <= carry_d;
            p_q         <= p_d;
            v_q         <= v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign sn        = sn_q;
    assign ZR        = zr_q;
    assign carry     = carry_q;
    assign P         = p_q;
    assign V         = v_q;

`ifdef ALU_STICKY_OVF_EN
    logic v_sticky_d, v_sticky_q;

    // Sticky overflow: clear on v_clr, but a new overflow on the same edge wins.
    always_comb begin
        v_sticky_d = v_sticky_q;
        if (v_clr) begin
            v_sticky_d = 1'b0;
        end
        if (in_valid && v_calc) begin
            v_sticky_d = 1'b1;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_sticky_q <= 1'b0;
        end else begin
            v_sticky_q <= v_sticky_d;
        end
    end

    assign v_sticky = v_sticky_q;
`endif

endmodule

// File: tb/tb_alu16_flags.sv
// tb_alu16_flags: directed-vector bench for alu16_flags with hand-computed
// expected results and flags. Covers the sticky-overflow port set when
// ALU_STICKY_OVF_EN is defined.
module tb_alu16_flags;

    localparam int WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_RSV = 3'b101;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             sn;
    logic             ZR;
    logic             carry;
    logic             P;
    logic             V;
`ifdef ALU_STICKY_OVF_EN
    logic             v_clr;
    logic             v_sticky;
`endif

    int tests_run;
    int tests_failed;

    alu16_flags #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .s         (s),
        .sn        (sn),
        .ZR        (ZR),
        .carry     (carry),
        .P         (P),
        .V         (V)
`ifdef ALU_STICKY_OVF_EN
        ,
        .v_clr     (v_clr),
        .v_sticky  (v_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare the full registered output bundle against hand-computed values.
    task automatic check_out(input string tag, input logic exp_valid, input logic [WIDTH-1:0] exp_s,
                             input logic exp_sn, input logic exp_zr, input logic exp_c,
                             input logic exp_p, input logic exp_v);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, ".s"},         32'(s),         32'(exp_s));
        check({tag, ".sn"},        32'(sn),        32'(exp_sn));
        check({tag, ".ZR"},        32'(ZR),        32'(exp_zr));
        check({tag, ".carry"},     32'(carry),     32'(exp_c));
        check({tag, ".P"},         32'(P),         32'(exp_p));
        check({tag, ".V"},         32'(V),         32'(exp_v));
    endtask

    // Called at a negedge: present one operation, then return at the next negedge.
    task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        op       = OP_ADD;
        a        = 16'h5a5a;
        b        = 16'h5a5a;
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = OP_ADD;
        a        = 16'hffff;
        b        = 16'h0001;
`ifdef ALU_STICKY_OVF_EN
        v_clr    = 1'b0;
`endif

        // Reset held two cycles with operations offered: all outputs stay zero.
        @(negedge clk);
        check_out("reset1", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_out("reset2", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // First accepted op after release appears one cycle later.
        run_op(OP_ADD, 16'h8fff, 16'h8000);
        check_out("add_carry_ovf", 1'b1, 16'h0fff, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        run_op(OP_ADD, 16'hfffe, 16'h0002);
        check_out("add_wrap_zero", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op(OP_ADD, 16'haaaa, 16'h5555);
        check_out("add_all_ones", 1'b1, 16'hffff, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(OP_ADD, 16'h7fff, 16'h0001);
        check_out("add_pos_ovf", 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        run_op(OP_SUB, 16'h0000, 16'h0001);
        check_out("sub_borrow", 1'b1, 16'hffff, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op(OP_SUB, 16'h8000, 16'h0001);
        check_out("sub_neg_ovf", 1'b1, 16'h7fff, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(OP_SUB, 16'h1234, 16'h1234);
        check_out("sub_equal", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Carry set first so the logic ops must actively clear it.
        run_op(OP_ADD, 16'hffff, 16'hffff);
        check_out("add_carry_neg", 1'b1, 16'hfffe, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(OP_XOR, 16'h1234, 16'h1234);
        check_out("xor_zero", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(OP_AND, 16'hff00, 16'h0ff0);
        check_out("and", 1'b1, 16'h0f00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(OP_OR, 16'h8000, 16'h0001);
        check_out("or", 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(OP_XOR, 16'h00ff, 16'h0001);
        check_out("xor_odd", 1'b1, 16'h00fe, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(OP_RSV, 16'hffff, 16'h0001);
        check_out("reserved", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Four back-to-back ops, then idle: out_valid drops, results hold.
        run_op(OP_ADD, 16'h0001, 16'h0002);
        check_out("b2b0", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(OP_SUB, 16'h0010, 16'h0001);
        check_out("b2b1", 1'b1, 16'h000f, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(OP_OR, 16'hf000, 16'h0f00);
        check_out("b2b2", 1'b1, 16'hff00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(OP_ADD, 16'h7000, 16'h7000);
        check_out("b2b3", 1'b1, 16'he000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        check_out("hold1", 1'b0, 16'he000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        check_out("hold2", 1'b0, 16'he000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef ALU_STICKY_OVF_EN
        // The overflow above (b2b3) set the sticky flag.
        check("sticky_set", 32'(v_sticky), 32'd1);
        run_op(OP_ADD, 16'h0001, 16'h0001);
        check("sticky_hold", 32'(v_sticky), 32'd1);
        v_clr = 1'b1;
        idle_cycle();
        check("sticky_clr", 32'(v_sticky), 32'd0);
        run_op(OP_ADD, 16'h7fff, 16'h7fff);
        check("sticky_set_wins", 32'(v_sticky), 32'd1);
        v_clr = 1'b0;
        idle_cycle();
        check("sticky_keep", 32'(v_sticky), 32'd1);
`endif

        // Reset discards an operation offered on the same edge.
        rst = 1'b1;
        run_op(OP_ADD, 16'h8fff, 16'h8000);
        check_out("reset_inflight", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_STICKY_OVF_EN
        check("sticky_reset", 32'(v_sticky), 32'd0);
`endif
        rst = 1'b0;
        idle_cycle();
        check("post_reset_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
